// File: rtl/data_c_pipe_intc_s2m_with_addr.sv
// Single-slave to multi-master packet router.
// An address beat picks a destination port; the following packet (ending
// with s_last) is forwarded to that port only. Out-of-range destinations
// are reported on route_err and the packet is swallowed. The output stage
// is a register plus a one-entry skid, so s_ready never depends on m_ready.
module data_c_pipe_intc_s2m_with_addr #(
  parameter int NUM   = 8,
  parameter int DSIZE = 32,
  parameter int NSIZE = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 addr_valid,
  input  logic [NSIZE-1:0]     addr_data,
  output logic                 addr_ready,
  input  logic                 s_valid,
  input  logic [DSIZE-1:0]     s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [NUM-1:0]       m_valid,
  output logic [NUM*DSIZE-1:0] m_data,
  output logic [NUM-1:0]       m_last,
  input  logic [NUM-1:0]       m_ready,
  output logic                 route_err
);

  localparam int TAGS = 1 << NSIZE;

  typedef enum logic [1:0] {IDLE, OPEN, DROP} state_t;

  state_t             state_reg, state_next;
  logic               addr_ready_reg;
  logic               route_err_reg;
  logic [NSIZE-1:0]   route_tag_reg;

  logic               out_vld_reg, out_last_reg;
  logic [DSIZE-1:0]   out_data_reg;
  logic [NSIZE-1:0]   out_tag_reg;
  logic               skid_vld_reg, skid_last_reg;
  logic [DSIZE-1:0]   skid_data_reg;
  logic [NSIZE-1:0]   skid_tag_reg;

  logic               addr_hs, addr_bad, beat_any, beat_fwd, out_free;
  logic [TAGS-1:0]    ready_pad;

  // With NUM a power of two every index is valid, so the range check vanishes.
  generate
    if (TAGS == NUM) begin : g_full_range
      assign addr_bad = 1'b0;
    end else begin : g_part_range
      assign addr_bad = (32'(addr_data) >= NUM);
    end
  endgenerate

  // Ready vector widened to every encodable tag so the lookup is never out of range.
  genvar gi;
  generate
    for (gi = 0; gi < TAGS; gi++) begin : g_ready_pad
      if (gi < NUM) begin : g_real
        assign ready_pad[gi] = m_ready[gi];
      end else begin : g_none
        assign ready_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign addr_ready = addr_ready_reg;
  assign route_err  = route_err_reg;
  assign addr_hs    = addr_valid && addr_ready_reg;
  assign beat_any   = s_valid && s_ready;
  assign beat_fwd   = beat_any && (state_reg == OPEN);
  assign out_free   = !out_vld_reg || ready_pad[out_tag_reg];

  // Route FSM: next state and upstream ready.
  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (addr_hs) state_next = addr_bad ? DROP : OPEN;
      end
      OPEN: begin
        s_ready = !skid_vld_reg;
        if (s_valid && !skid_vld_reg && s_last) state_next = IDLE;
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Route state, registered addr_ready (low in reset), route tag and error pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_ready_reg <= 1'b0;
      route_tag_reg  <= '0;
      route_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_ready_reg <= (state_next == IDLE);
      route_err_reg  <= addr_hs && addr_bad;
      if (addr_hs && !addr_bad) route_tag_reg <= addr_data;
    end
  end

  // Output register with one-entry skid; skid always drains before new beats.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_vld_reg   <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
      skid_vld_reg  <= 1'b0;
      skid_last_reg <= 1'b0;
      skid_data_reg <= '0;
      skid_tag_reg  <= '0;
    end else if (out_free) begin
      if (skid_vld_reg) begin
        out_vld_reg  <= 1'b1;
        out_last_reg <= skid_last_reg;
        out_data_reg <= skid_data_reg;
        out_tag_reg  <= skid_tag_reg;
        skid_vld_reg <= 1'b0;
      end else if (beat_fwd) begin
        out_vld_reg  <= 1'b1;
        out_last_reg <= s_last;
        out_data_reg <= s_data;
        out_tag_reg  <= route_tag_reg;
      end else begin
        out_vld_reg  <= 1'b0;
        out_last_reg <= 1'b0;
      end
    end else if (beat_fwd) begin
      skid_vld_reg  <= 1'b1;
      skid_last_reg <= s_last;
      skid_data_reg <= s_data;
      skid_tag_reg  <= route_tag_reg;
    end
  end

  // Fan the single output register out to every lane; only the tagged lane is valid.
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_lane
      assign m_valid[gi]               = out_vld_reg && (out_tag_reg == NSIZE'(gi));
      assign m_last[gi]                = out_last_reg && (out_tag_reg == NSIZE'(gi));
      assign m_data[gi*DSIZE +: DSIZE] = out_data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_data_c_pipe_intc_s2m_with_addr.sv
// Bench for the S2M addressed router: directed scenarios plus random traffic,
// checked against an in-order queue of expected {port, data, last} beats.
module tb_data_c_pipe_intc_s2m_with_addr;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         rst;
  // NUM=8 instance
  logic         addr_valid, addr_ready;
  logic [2:0]   addr_data;
  logic         s_valid, s_last, s_ready;
  logic [31:0]  s_data;
  logic [7:0]   m_valid, m_last, m_ready;
  logic [255:0] m_data;
  logic         route_err;
  // NUM=6 instance
  logic         a6_valid, a6_ready;
  logic [2:0]   a6_data;
  logic         s6_valid, s6_last, s6_ready;
  logic [31:0]  s6_data;
  logic [5:0]   m6_valid, m6_last, m6_ready;
  logic [191:0] m6_data;
  logic         err6;

  data_c_pipe_intc_s2m_with_addr #(.NUM(8), .DSIZE(32)) dut8 (
    .clock(clock), .rst(rst),
    .addr_valid(addr_valid), .addr_data(addr_data), .addr_ready(addr_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .route_err(route_err)
  );

  data_c_pipe_intc_s2m_with_addr #(.NUM(6), .DSIZE(32)) dut6 (
    .clock(clock), .rst(rst),
    .addr_valid(a6_valid), .addr_data(a6_data), .addr_ready(a6_ready),
    .s_valid(s6_valid), .s_data(s6_data), .s_last(s6_last), .s_ready(s6_ready),
    .m_valid(m6_valid), .m_data(m6_data), .m_last(m6_last), .m_ready(m6_ready),
    .route_err(err6)
  );

  typedef struct packed {
    logic [2:0]  tag;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t        exp_q[$];
  int           tests = 0;
  int           fails = 0;
  logic [2:0]   cur_tag = 3'd0;
  logic         rand_ready = 1'b0;
  logic         addr_hs, s_hs, a6_hs, s6_hs;
  logic [7:0]   smp_mv, smp_ml;
  logic [255:0] smp_md;
  logic         smp_ar, smp_sr;
  logic [5:0]   smp_mv6, smp_ml6;
  logic [191:0] smp_md6;
  logic         smp_err6;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, score the downstream side, record upstream
  // handshakes into the model, then return just after the posedge.
  task automatic tick();
    int    k;
    beat_t e;
    @(negedge clock);
    smp_mv = m_valid;  smp_ml = m_last;  smp_md = m_data;
    smp_ar = addr_ready; smp_sr = s_ready;
    smp_mv6 = m6_valid; smp_ml6 = m6_last; smp_md6 = m6_data; smp_err6 = err6;
    addr_hs = addr_valid && addr_ready;
    s_hs    = s_valid && s_ready;
    a6_hs   = a6_valid && a6_ready;
    s6_hs   = s6_valid && s6_ready;
    chk("onehot", 64'($countones(m_valid) <= 1), 64'd1);
    chk("last_qual", 64'(m_last & ~m_valid), 64'd0);
    chk("err8_never", 64'(route_err), 64'd0);
    if ((m_valid & m_ready) != 8'h00) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (m_valid[i] && m_ready[i]) k = i;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_port", 64'(k), 64'(e.tag));
        chk("sb_data", 64'(m_data[k*32 +: 32]), 64'(e.data));
        chk("sb_last", 64'(m_last[k]), 64'(e.last));
      end
    end
    if (addr_hs) cur_tag = addr_data;
    if (s_hs) exp_q.push_back('{tag: cur_tag, data: s_data, last: s_last});
    @(posedge clock);
    #1;
    if (rand_ready) m_ready = 8'($urandom | $urandom);
  endtask

  task automatic send_addr(input logic [2:0] a, input string tag);
    logic done = 1'b0;
    addr_valid = 1'b1;
    addr_data  = a;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      done = addr_hs;
    end
    chk(tag, 64'(done), 64'd1);
    addr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input string tag);
    logic done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      done = s_hs;
    end
    chk(tag, 64'(done), 64'd1);
    s_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    addr_valid = 1'b0; addr_data = 3'd0;
    s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
    m_ready = 8'hFF;
    a6_valid = 1'b0; a6_data = 3'd0;
    s6_valid = 1'b0; s6_data = 32'd0; s6_last = 1'b0;
    m6_ready = 6'h3F;

    // Reset held for three cycles.
    repeat (3) begin
      tick();
      chk("rst_addr_ready", 64'(smp_ar), 64'd0);
      chk("rst_s_ready", 64'(smp_sr), 64'd0);
      chk("rst_m_valid", 64'(smp_mv), 64'd0);
      chk("rst_m_data_zero", 64'(smp_md == 256'd0), 64'd1);
    end
    rst = 1'b0;
    addr_valid = 1'b1;
    addr_data  = 3'd5;
    tick();
    tick();
    chk("t1_addr_ready", 64'(smp_ar), 64'd1);
    chk("t1_s_ready", 64'(smp_sr), 64'd0);
    chk("t1_m_valid", 64'(smp_mv), 64'd0);
    chk("t1_addr_hs", 64'(addr_hs), 64'd1);
    addr_valid = 1'b0;

    // Route 5, four beats back to back, all downstream ready.
    send_beat(32'hA0, 1'b0, "t2_b0");
    for (int i = 1; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'hA0 + 32'(i); s_last = (i == 3);
      tick();
      chk("t2_hs", 64'(s_hs), 64'd1);
      chk("t2_m_valid", 64'(smp_mv), 64'h20);
      chk("t2_m_last", 64'(smp_ml), 64'h00);
    end
    s_valid = 1'b0;
    tick();
    chk("t2_m_valid_end", 64'(smp_mv), 64'h20);
    chk("t2_m_last_end", 64'(smp_ml), 64'h20);
    tick();
    chk("t2_m_valid_idle", 64'(smp_mv), 64'h00);

    // Backpressure on port 2: out + skid fill, then drain in order.
    m_ready = 8'hFB;
    send_addr(3'd2, "t3_addr");
    send_beat(32'hC0, 1'b0, "t3_b0");
    send_beat(32'hC1, 1'b0, "t3_b1");
    s_valid = 1'b1; s_data = 32'hC2; s_last = 1'b0;
    repeat (3) begin
      tick();
      chk("t3_stall_s_ready", 64'(smp_sr), 64'd0);
      chk("t3_stall_m_valid", 64'(smp_mv), 64'h04);
    end
    m_ready = 8'hFF;
    send_beat(32'hC2, 1'b0, "t3_b2");
    send_beat(32'hC3, 1'b1, "t3_b3");
    repeat (4) tick();
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // Port 1 last beat stalled, then a single-beat packet to port 6 queued behind it.
    send_addr(3'd1, "t4_addr1");
    send_beat(32'hD0, 1'b0, "t4_d0");
    send_beat(32'hD1, 1'b1, "t4_d1");
    m_ready = 8'hFD;
    send_addr(3'd6, "t4_addr6");
    send_beat(32'hE0, 1'b1, "t4_e0");
    repeat (3) begin
      tick();
      chk("t4_hold_port1", 64'(smp_mv), 64'h02);
    end
    m_ready = 8'hFF;
    tick();
    chk("t4_port1_last", 64'(smp_mv), 64'h02);
    tick();
    chk("t4_port6_after", 64'(smp_mv), 64'h40);
    tick();
    chk("t4_idle", 64'(smp_mv), 64'h00);

    // NUM=6: address 7 is out of range, packet swallowed.
    a6_valid = 1'b1; a6_data = 3'd7;
    tick();
    chk("t5_addr_hs", 64'(a6_hs), 64'd1);
    a6_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s6_valid = 1'b1; s6_data = 32'h61 + 32'(i); s6_last = (i == 2);
      tick();
      chk("t5_err_pulse", 64'(smp_err6), 64'(i == 0));
      chk("t5_drop_hs", 64'(s6_hs), 64'd1);
      chk("t5_m_valid", 64'(smp_mv6), 64'd0);
    end
    s6_valid = 1'b0;
    tick();
    chk("t5_m_valid_after", 64'(smp_mv6), 64'd0);
    chk("t5_err_low", 64'(smp_err6), 64'd0);
    a6_valid = 1'b1; a6_data = 3'd2;
    tick();
    chk("t5_next_addr", 64'(a6_hs), 64'd1);
    a6_valid = 1'b0;
    s6_valid = 1'b1; s6_data = 32'h77; s6_last = 1'b1;
    tick();
    chk("t5_beat_hs", 64'(s6_hs), 64'd1);
    s6_valid = 1'b0;
    tick();
    chk("t5_port2_valid", 64'(smp_mv6), 64'h04);
    chk("t5_port2_data", 64'(smp_md6[64 +: 32]), 64'h77);
    chk("t5_port2_last", 64'(smp_ml6), 64'h04);

    // Random traffic with random downstream ready.
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      send_addr(3'($urandom_range(0, 7)), "rnd_addr");
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_beat($urandom, (i == n - 1), "rnd_beat");
      end
    end
    rand_ready = 1'b0;
    m_ready = 8'hFF;
    repeat (6) tick();
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with out and skid both occupied.
    m_ready = 8'h00;
    send_addr(3'd4, "t6_addr4");
    send_beat(32'hF0, 1'b0, "t6_f0");
    send_beat(32'hF1, 1'b0, "t6_f1");
    s_valid = 1'b1; s_data = 32'hF2; s_last = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_m_valid", 64'(m_valid), 64'd0);
    chk("t6_async_s_ready", 64'(s_ready), 64'd0);
    chk("t6_async_addr_ready", 64'(addr_ready), 64'd0);
    s_valid = 1'b0;
    exp_q.delete();
    repeat (3) begin
      tick();
      chk("t6_rst_m_valid", 64'(smp_mv), 64'd0);
    end
    rst = 1'b0;
    m_ready = 8'hFF;
    repeat (2) begin
      tick();
      chk("t6_no_partial", 64'(smp_mv), 64'd0);
    end
    send_addr(3'd3, "t6_addr3");
    send_beat(32'h55, 1'b1, "t6_b55");
    tick();
    chk("t6_port3_valid", 64'(smp_mv), 64'h08);
    chk("t6_port3_data", 64'(smp_md[96 +: 32]), 64'h55);
    chk("t6_port3_last", 64'(smp_ml), 64'h08);
    tick();
    chk("t6_idle", 64'(smp_mv), 64'd0);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
